// File: rtl/mem_wb_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_wb_stage_pkg
// Purpose  : Shared encodings for the MEM-stage memory access / MEM-WB register.
// Revision : 1.0  initial release
// ============================================================================
package mem_wb_stage_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    // MemSize encodings; 2'b11 is treated as a word access.
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // MemtoReg encodings consumed by the write-back mux.
    localparam logic [1:0] WB_SEL_ALU = 2'b00;
    localparam logic [1:0] WB_SEL_MEM = 2'b01;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_t;

    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic ok;
        case (size)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = ~addr_lo[0];
            default: ok = (addr_lo == 2'b00);
        endcase
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_wb_stage_load_align.sv
`default_nettype none
// ============================================================================
// Module   : mem_load_align
// Purpose  : Little-endian lane select and sign/zero extension of load data.
// Revision : 1.0  initial release
// ============================================================================
module mem_load_align
    import mem_wb_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] load_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = 8'h00;
        case (addr_lo)
            2'd0:    w_byte = rdata[7:0];
            2'd1:    w_byte = rdata[15:8];
            2'd2:    w_byte = rdata[23:16];
            default: w_byte = rdata[31:24];
        endcase
        w_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        load_data = rdata;
        case (size)
            SZ_BYTE: load_data = {{24{~is_unsigned & w_byte[7]}}, w_byte};
            SZ_HALF: load_data = {{16{~is_unsigned & w_half[15]}}, w_half};
            default: load_data = rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_wb_stage
// Purpose  : MEM-stage data-memory access with stall handshake, fused with
//            the MEM/WB pipeline register.
// Revision : 1.0  initial release
// ============================================================================
module mem_wb_stage
    import mem_wb_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MEM_valid,
    input  logic [31:0] MEM_ALUout,
    input  logic [31:0] MEM_WriteData,
    input  logic        MEM_MemRead,
    input  logic        MEM_MemWrite,
    input  logic [1:0]  MEM_MemSize,
    input  logic        MEM_MemUnsigned,
    input  logic [1:0]  MEM_MemtoReg,
    input  logic        MEM_RegWrite,
    input  logic [4:0]  MEM_WriteReg,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        mem_stall,
    output logic [31:0] WB_ALUout,
    output logic [31:0] WB_MemReadData,
    output logic [1:0]  WB_MemtoReg,
    output logic        WB_RegWrite,
    output logic [4:0]  WB_WriteReg,
    output logic        WB_valid,
    output logic        WB_misalign
);

    mem_state_t  r_state;

    logic [1:0]  w_addr_lo;
    logic        w_mem_op;
    logic        w_aligned;
    logic        w_access;
    logic        w_misalign;
    logic        w_req;
    logic        w_stall;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_load_data;

    logic [31:0] r_wb_aluout;
    logic [31:0] r_wb_rdata;
    logic [1:0]  r_wb_memtoreg;
    logic        r_wb_regwrite;
    logic [4:0]  r_wb_writereg;
    logic        r_wb_valid;
    logic        r_wb_misalign;

    assign w_addr_lo  = MEM_ALUout[1:0];
    assign w_mem_op   = MEM_valid & (MEM_MemRead | MEM_MemWrite);
    assign w_aligned  = is_aligned(MEM_MemSize, w_addr_lo);
    assign w_access   = w_mem_op & w_aligned;
    assign w_misalign = w_mem_op & ~w_aligned;

    // Gated by rst_n so the request drops the instant reset asserts.
    assign w_req   = rst_n & (((r_state == ST_IDLE) & w_access) | (r_state == ST_WAIT));
    assign w_stall = w_req & ~dmem_ack;

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = MEM_WriteData;
        case (MEM_MemSize)
            SZ_BYTE: begin
                w_be    = 4'b0001 << w_addr_lo;
                w_wdata = {4{MEM_WriteData[7:0]}};
            end
            SZ_HALF: begin
                w_be    = 4'b0011 << w_addr_lo;
                w_wdata = {2{MEM_WriteData[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = MEM_WriteData;
            end
        endcase
    end

    assign dmem_req   = w_req;
    assign dmem_we    = w_req & MEM_MemWrite;
    assign dmem_addr  = w_req ? {MEM_ALUout[31:2], 2'b00} : 32'h0;
    assign dmem_be    = w_req ? w_be : 4'b0000;
    assign dmem_wdata = w_req ? w_wdata : 32'h0;
    assign mem_stall  = w_stall;

    mem_load_align u_load_align (
        .rdata       (dmem_rdata),
        .addr_lo     (w_addr_lo),
        .size        (MEM_MemSize),
        .is_unsigned (MEM_MemUnsigned),
        .load_data   (w_load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_access && !dmem_ack) r_state <= ST_WAIT;
                ST_WAIT: if (dmem_ack)              r_state <= ST_IDLE;
                default:                            r_state <= ST_IDLE;
            endcase
        end
    end

    // A stalled cycle inserts a bubble; data fields hold their last values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_aluout   <= 32'h0;
            r_wb_rdata    <= 32'h0;
            r_wb_memtoreg <= WB_SEL_ALU;
            r_wb_regwrite <= 1'b0;
            r_wb_writereg <= 5'd0;
            r_wb_valid    <= 1'b0;
            r_wb_misalign <= 1'b0;
        end else if (!w_stall) begin
            r_wb_aluout   <= MEM_ALUout;
            r_wb_rdata    <= (w_access & MEM_MemRead) ? w_load_data : 32'h0;
            r_wb_memtoreg <= MEM_MemtoReg;
            r_wb_regwrite <= MEM_RegWrite & ~w_misalign;
            r_wb_writereg <= MEM_WriteReg;
            r_wb_valid    <= MEM_valid;
            r_wb_misalign <= w_misalign;
        end else begin
            r_wb_regwrite <= 1'b0;
            r_wb_valid    <= 1'b0;
            r_wb_misalign <= 1'b0;
        end
    end

    assign WB_ALUout      = r_wb_aluout;
    assign WB_MemReadData = r_wb_rdata;
    assign WB_MemtoReg    = r_wb_memtoreg;
    assign WB_RegWrite    = r_wb_regwrite;
    assign WB_WriteReg    = r_wb_writereg;
    assign WB_valid       = r_wb_valid;
    assign WB_misalign    = r_wb_misalign;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_wb_stage
// Purpose  : Scoreboard bench for mem_wb_stage with a randomized memory model.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_wb_stage;

    logic        clk;
    logic        rst_n;
    logic        MEM_valid;
    logic [31:0] MEM_ALUout;
    logic [31:0] MEM_WriteData;
    logic        MEM_MemRead;
    logic        MEM_MemWrite;
    logic [1:0]  MEM_MemSize;
    logic        MEM_MemUnsigned;
    logic [1:0]  MEM_MemtoReg;
    logic        MEM_RegWrite;
    logic [4:0]  MEM_WriteReg;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic        mem_stall;
    logic [31:0] WB_ALUout;
    logic [31:0] WB_MemReadData;
    logic [1:0]  WB_MemtoReg;
    logic        WB_RegWrite;
    logic [4:0]  WB_WriteReg;
    logic        WB_valid;
    logic        WB_misalign;

    mem_wb_stage dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .MEM_valid       (MEM_valid),
        .MEM_ALUout      (MEM_ALUout),
        .MEM_WriteData   (MEM_WriteData),
        .MEM_MemRead     (MEM_MemRead),
        .MEM_MemWrite    (MEM_MemWrite),
        .MEM_MemSize     (MEM_MemSize),
        .MEM_MemUnsigned (MEM_MemUnsigned),
        .MEM_MemtoReg    (MEM_MemtoReg),
        .MEM_RegWrite    (MEM_RegWrite),
        .MEM_WriteReg    (MEM_WriteReg),
        .dmem_req        (dmem_req),
        .dmem_we         (dmem_we),
        .dmem_addr       (dmem_addr),
        .dmem_be         (dmem_be),
        .dmem_wdata      (dmem_wdata),
        .dmem_rdata      (dmem_rdata),
        .dmem_ack        (dmem_ack),
        .mem_stall       (mem_stall),
        .WB_ALUout       (WB_ALUout),
        .WB_MemReadData  (WB_MemReadData),
        .WB_MemtoReg     (WB_MemtoReg),
        .WB_RegWrite     (WB_RegWrite),
        .WB_WriteReg     (WB_WriteReg),
        .WB_valid        (WB_valid),
        .WB_misalign     (WB_misalign)
    );

    typedef struct {
        logic [31:0] alu;
        logic [31:0] mrd;
        logic [1:0]  m2r;
        logic        regw;
        logic [4:0]  wreg;
        logic        mis;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   n_checks = 0;
    int   n_pass   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model (byte-lane arithmetic) ----------------
    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic ref_aligned(input logic [1:0] size, input logic [31:0] addr);
        return (addr % nbytes(size)) == 0;
    endfunction

    function automatic logic [3:0] ref_be(input logic [1:0] size, input logic [31:0] addr);
        logic [3:0] be;
        int start;
        int n;
        n = nbytes(size);
        start = (n == 4) ? 0 : int'(addr % 4);
        for (int i = 0; i < 4; i++) be[i] = (i >= start) && (i < start + n);
        return be;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [1:0] size, input logic [31:0] d);
        if (size == 2'd0) return {24'h0, d[7:0]} * 32'h01010101;
        if (size == 2'd1) return {16'h0, d[15:0]} * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] rdata, input logic [31:0] addr,
                                             input logic [1:0] size, input logic uns);
        logic [31:0] v;
        int sh;
        if (nbytes(size) == 4) return rdata;
        sh = (nbytes(size) == 1) ? 8 * int'(addr % 4) : 16 * int'((addr / 2) % 2);
        if (nbytes(size) == 1) begin
            v = (rdata >> sh) & 32'hFF;
            if (!uns && v >= 32'h80) v = v | 32'hFFFFFF00;
        end else begin
            v = (rdata >> sh) & 32'hFFFF;
            if (!uns && v >= 32'h8000) v = v | 32'hFFFF0000;
        end
        return v;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n === 1'b1 && WB_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL wb_unexpected: got WB_valid=1 with ALUout=%h, expected no pending instruction", WB_ALUout);
            end else begin
                m_e = sb.pop_front();
                chk("wb_aluout",   WB_ALUout,      m_e.alu);
                chk("wb_rdata",    WB_MemReadData, m_e.mrd);
                chk("wb_memtoreg", {30'h0, WB_MemtoReg}, {30'h0, m_e.m2r});
                chk("wb_regwrite", {31'h0, WB_RegWrite}, {31'h0, m_e.regw});
                chk("wb_writereg", {27'h0, WB_WriteReg}, {27'h0, m_e.wreg});
                chk("wb_misalign", {31'h0, WB_misalign}, {31'h0, m_e.mis});
            end
        end
    end

    // ---------------- driver: one instruction, called at posedge+1 ----------------
    task automatic issue(input logic valid, input logic rd, input logic wr, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input logic [1:0] m2r, input logic regw,
                         input logic [4:0] wreg, input int lat, input logic stray_ack);
        logic access;
        logic mis;
        exp_t e;
        access = valid && (rd || wr) && ref_aligned(size, addr);
        mis    = valid && (rd || wr) && !ref_aligned(size, addr);
        MEM_valid = valid;  MEM_ALUout = addr;  MEM_WriteData = wdata;
        MEM_MemRead = rd;   MEM_MemWrite = wr;  MEM_MemSize = size;
        MEM_MemUnsigned = uns; MEM_MemtoReg = m2r; MEM_RegWrite = regw;
        MEM_WriteReg = wreg; dmem_rdata = rdata;
        if (valid) begin
            e.alu  = addr;
            e.mrd  = (access && rd) ? ref_load(rdata, addr, size, uns) : 32'h0;
            e.m2r  = m2r;
            e.regw = regw && !mis;
            e.wreg = wreg;
            e.mis  = mis;
            sb.push_back(e);
        end
        if (access) begin
            for (int c = 0; c <= lat; c++) begin
                dmem_ack = (c == lat);
                @(negedge clk);
                chk("dmem_req",  {31'h0, dmem_req},  32'd1);
                chk("mem_stall", {31'h0, mem_stall}, {31'h0, c < lat});
                if (c == 0) begin
                    chk("dmem_we",    {31'h0, dmem_we}, {31'h0, wr});
                    chk("dmem_addr",  dmem_addr, {addr[31:2], 2'b00});
                    chk("dmem_be",    {28'h0, dmem_be}, {28'h0, ref_be(size, addr)});
                    if (wr) chk("dmem_wdata", dmem_wdata, ref_wdata(size, wdata));
                end else begin
                    chk("bubble_valid", {31'h0, WB_valid},    32'd0);
                    chk("bubble_regw",  {31'h0, WB_RegWrite}, 32'd0);
                end
                @(posedge clk); #1;
            end
            dmem_ack = 1'b0;
        end else begin
            dmem_ack = stray_ack;
            @(negedge clk);
            chk("no_req",   {31'h0, dmem_req},  32'd0);
            chk("no_stall", {31'h0, mem_stall}, 32'd0);
            @(posedge clk); #1;
            dmem_ack = 1'b0;
        end
    endtask

    task automatic idle_inputs();
        MEM_valid = 1'b0; MEM_MemRead = 1'b0; MEM_MemWrite = 1'b0; MEM_RegWrite = 1'b0;
        dmem_ack = 1'b0;
    endtask

    task automatic chk_wb_zero(input string tag);
        chk({tag, "_wb_alu"},   WB_ALUout,      32'h0);
        chk({tag, "_wb_rdata"}, WB_MemReadData, 32'h0);
        chk({tag, "_wb_ctl"},   {22'h0, WB_MemtoReg, WB_RegWrite, WB_WriteReg, WB_valid, WB_misalign}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
        $fatal(1);
    end

    initial begin
        logic [1:0]  sz;
        logic [31:0] ad;
        int          kind;
        rst_n = 1'b0;
        // A legal load presented during reset must not raise a request.
        MEM_valid = 1'b1; MEM_ALUout = 32'h0000_2000; MEM_WriteData = 32'h0;
        MEM_MemRead = 1'b1; MEM_MemWrite = 1'b0; MEM_MemSize = 2'd2; MEM_MemUnsigned = 1'b0;
        MEM_MemtoReg = 2'd1; MEM_RegWrite = 1'b1; MEM_WriteReg = 5'd3;
        dmem_rdata = 32'h0; dmem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_req",   {31'h0, dmem_req},  32'd0);
        chk("rst_stall", {31'h0, mem_stall}, 32'd0);
        chk_wb_zero("rst");
        idle_inputs();
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed cases from the block's bring-up list.
        issue(1, 0, 0, 2'd2, 0, 32'h0000_1234, 32'h0, 32'h0, 2'd0, 1, 5'd5, 0, 0);
        issue(1, 1, 0, 2'd0, 0, 32'h0000_1001, 32'h0, 32'h1122_8344, 2'd1, 1, 5'd6, 0, 0);
        issue(1, 1, 0, 2'd0, 1, 32'h0000_1001, 32'h0, 32'h1122_8344, 2'd1, 1, 5'd7, 0, 0);
        issue(1, 1, 0, 2'd1, 0, 32'h0000_1002, 32'h0, 32'h8001_0000, 2'd1, 1, 5'd8, 1, 0);
        issue(1, 1, 0, 2'd2, 0, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 2'd1, 1, 5'd9, 2, 0);
        issue(1, 0, 1, 2'd1, 0, 32'h0000_0102, 32'h0000_ABCD, 32'h0, 2'd0, 0, 5'd0, 3, 0);
        issue(1, 1, 0, 2'd2, 0, 32'h0000_1002, 32'h0, 32'h1234_5678, 2'd1, 1, 5'd10, 0, 1);
        issue(1, 0, 1, 2'd3, 0, 32'h0000_2001, 32'h5555_AAAA, 32'h0, 2'd0, 0, 5'd0, 0, 1);

        // Reset asserted in the middle of a 5-cycle load.
        MEM_valid = 1'b1; MEM_ALUout = 32'h0000_3000; MEM_MemRead = 1'b1; MEM_MemWrite = 1'b0;
        MEM_MemSize = 2'd2; MEM_RegWrite = 1'b1; MEM_WriteReg = 5'd12; MEM_MemtoReg = 2'd1;
        dmem_ack = 1'b0;
        @(negedge clk);
        chk("wait_stall", {31'h0, mem_stall}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("wait_stall2", {31'h0, mem_stall}, 32'd1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("arst_req",   {31'h0, dmem_req},  32'd0);
        chk("arst_stall", {31'h0, mem_stall}, 32'd0);
        chk_wb_zero("arst");
        idle_inputs();
        dmem_ack = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        // Stale ack arrives right after reset; the ALU op must pass untouched.
        issue(1, 0, 0, 2'd2, 0, 32'h0000_00AA, 32'h0, 32'h0, 2'd0, 1, 5'd13, 0, 1);
        issue(1, 0, 0, 2'd2, 0, 32'h0000_00BB, 32'h0, 32'h0, 2'd0, 1, 5'd14, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 250; i++) begin
            kind = $urandom_range(0, 2);
            sz   = 2'($urandom_range(0, 3));
            ad   = $urandom;
            if ($urandom_range(0, 3) != 0) ad = ad - (ad % nbytes(sz));
            issue(($urandom_range(0, 9) != 0), (kind == 1), (kind == 2), sz, 1'($urandom_range(0, 1)),
                  ad, $urandom, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 31)), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
        end

        idle_inputs();
        for (int k = 0; k < 10 && sb.size() != 0; k++) @(posedge clk);
        @(negedge clk);
        #1;
        chk("sb_drain", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
